// File: rtl/fp_mul_pkg.sv
// ---------------------------------------------------------------------------
// fp_mul_pkg
// Shared types and constants for the fp_mul issue/collect wrapper.
//   MUL_PERIOD : clocks per multiplier frame (one operation per frame)
//   TAG_W      : width of the caller tag carried alongside each operation
//   fp32_t     : IEEE-754 single-precision field view
//   op_t       : queued operand pair {a, b, tag}
//   res_t      : captured result {c, ovf, tag}
// ---------------------------------------------------------------------------
package fp_mul_pkg;

    localparam int MUL_PERIOD = 26;
    localparam int TAG_W      = 4;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

    typedef struct packed {
        fp32_t             a;
        fp32_t             b;
        logic [TAG_W-1:0]  tag;
    } op_t;

    typedef struct packed {
        fp32_t             c;
        logic              ovf;
        logic [TAG_W-1:0]  tag;
    } res_t;

endpackage

// File: rtl/fp_sync_fifo.sv
// ---------------------------------------------------------------------------
// fp_sync_fifo
// Single-clock FIFO used for both the operand queue and the result queue.
// A push and a pop in the same cycle are both honoured. Pushes while full
// and pops while empty are ignored.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write wdata_i at the tail
//   wdata_i    : data to write
//   pop_i      : drop the head entry
//   rdata_o    : head entry (stale when empty)
//   full_o     : no free entries
//   empty_o    : no valid entries
//   count_o    : number of valid entries
// ---------------------------------------------------------------------------
module fp_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             doPush, doPop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rdPtr_q];
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;

    // Next-state for the pointers and occupancy count.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q + CW'(doPush) - CW'(doPop);
        if (doPush) wrPtr_d = nextPtr(wrPtr_q);
        if (doPop)  rdPtr_d = nextPtr(rdPtr_q);
    end

    // Control state; storage contents need no reset since empty hides them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= wdata_i;
    end

endmodule

// File: rtl/fp_mul_feeder.sv
// ---------------------------------------------------------------------------
// fp_mul_feeder
// Issue/collect stage around the frame-based sequential multiplier. Operand
// pairs are queued, handed to the multiplier at the frame boundary, tracked
// while in flight, and their results returned in order with their tags.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready : operand stream handshake (in_a, in_b, in_tag)
//   mul_rst           : active-high reset to the multiplier (~rst_n)
//   mul_a, mul_b      : registered operands presented to the multiplier
//   mul_c, mul_ovf    : multiplier result and overflow flag
//   out_valid/ready   : result stream handshake (out_c, out_ovf, out_tag)
//   busy              : anything queued, pending, in flight or unread
// ---------------------------------------------------------------------------
module fp_mul_feeder #(
    parameter int OPQ_DEPTH  = 4,
    parameter int RES_DEPTH  = 2,
    parameter int TAG_W      = fp_mul_pkg::TAG_W,
    parameter int MUL_PERIOD = fp_mul_pkg::MUL_PERIOD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             mul_rst,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic [31:0]      mul_c,
    input  logic             mul_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_c,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    import fp_mul_pkg::*;

    localparam int FCW = $clog2(MUL_PERIOD);

    logic [FCW-1:0]   fc_q, fc_d;
    logic [31:0]      mulA_q, mulA_d, mulB_q, mulB_d;
    logic             pendV_q, pendV_d, flyV_q, flyV_d;
    logic [TAG_W-1:0] pendTag_q, pendTag_d, flyTag_q, flyTag_d;

    logic loadEdge, sampleEdge, credit;
    logic opqPush, opqPop, opqFull, opqEmpty;
    logic resqPush, resqPop, resqFull, resqEmpty;
    logic [$clog2(OPQ_DEPTH+1)-1:0] opqCount;
    logic [$clog2(RES_DEPTH+1)-1:0] resqCount;
    op_t  opqIn, opqHead;
    res_t resqIn, resqHead;

    // The multiplier shares our reset so both frame counters start together.
    assign mul_rst = ~rst_n;
    assign mul_a   = mulA_q;
    assign mul_b   = mulB_q;

    assign in_ready = rst_n & ~opqFull;
    assign opqPush  = in_valid & in_ready;
    assign opqIn    = {in_a, in_b, in_tag};

    // loadEdge is the clock ending the last frame cycle; the multiplier then
    // samples our registers on the following edge (sampleEdge).
    assign loadEdge   = (fc_q == FCW'(MUL_PERIOD - 1));
    assign sampleEdge = (fc_q == '0);

    // Only issue if the op already in flight plus this one both fit in the
    // result queue, so a capture can never find it full.
    assign credit   = (int'(resqCount) + int'(flyV_q) + 1) <= RES_DEPTH;
    assign opqPop   = loadEdge & ~opqEmpty & credit;

    assign resqPush = sampleEdge & flyV_q;
    assign resqIn   = {mul_c, mul_ovf, flyTag_q};
    assign resqPop  = out_valid & out_ready;

    assign out_valid = ~resqEmpty;
    assign out_c     = resqEmpty ? '0 : resqHead.c;
    assign out_ovf   = resqEmpty ? 1'b0 : resqHead.ovf;
    assign out_tag   = resqEmpty ? '0 : resqHead.tag;
    assign busy      = ~opqEmpty | pendV_q | flyV_q | ~resqEmpty;

    fp_sync_fifo #(.WIDTH($bits(op_t)), .DEPTH(OPQ_DEPTH)) u_opq (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (opqPush),
        .wdata_i (opqIn),
        .pop_i   (opqPop),
        .rdata_o (opqHead),
        .full_o  (opqFull),
        .empty_o (opqEmpty),
        .count_o (opqCount)
    );

    fp_sync_fifo #(.WIDTH($bits(res_t)), .DEPTH(RES_DEPTH)) u_resq (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (resqPush),
        .wdata_i (resqIn),
        .pop_i   (resqPop),
        .rdata_o (resqHead),
        .full_o  (resqFull),
        .empty_o (resqEmpty),
        .count_o (resqCount)
    );

    // Frame position, issue at the load edge, and the pending-to-in-flight
    // hand-off at the sample edge. An empty or credit-blocked frame drives
    // zeros, which the multiplier turns into a harmless zero result.
    always_comb begin
        fc_d      = loadEdge ? '0 : fc_q + 1'b1;
        mulA_d    = mulA_q;
        mulB_d    = mulB_q;
        pendV_d   = pendV_q;
        pendTag_d = pendTag_q;
        flyV_d    = flyV_q;
        flyTag_d  = flyTag_q;
        if (loadEdge) begin
            if (opqPop) begin
                mulA_d    = opqHead.a;
                mulB_d    = opqHead.b;
                pendTag_d = opqHead.tag;
                pendV_d   = 1'b1;
            end else begin
                mulA_d    = '0;
                mulB_d    = '0;
                pendV_d   = 1'b0;
            end
        end
        if (sampleEdge) begin
            flyV_d   = pendV_q;
            flyTag_d = pendTag_q;
            pendV_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fc_q      <= '0;
            mulA_q    <= '0;
            mulB_q    <= '0;
            pendV_q   <= 1'b0;
            pendTag_q <= '0;
            flyV_q    <= 1'b0;
            flyTag_q  <= '0;
        end else begin
            fc_q      <= fc_d;
            mulA_q    <= mulA_d;
            mulB_q    <= mulB_d;
            pendV_q   <= pendV_d;
            pendTag_q <= pendTag_d;
            flyV_q    <= flyV_d;
            flyTag_q  <= flyTag_d;
        end
    end

    // A capture into a full result queue would silently lose a result.
    assert property (@(posedge clk) disable iff (!rst_n)
                     resqPush |-> (!resqFull || resqPop));

    assert property (@(posedge clk) disable iff (!rst_n)
                     int'(opqCount) <= OPQ_DEPTH);

endmodule
